// File: rtl/cmd_sched_pkg.sv
// Shared types for the command scheduler: FSM state encoding and the command
// codes understood by the executor.
package cmd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    CMD_NOP = 2'd0,
    CMD_TX  = 2'd1,
    CMD_RX  = 2'd2,
    CMD_CFG = 2'd3
  } cmd_code_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or above ptr,
// wrapping, returned as one-hot plus binary index.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the closest request to ptr wins last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(ptr) + off) % N_REQ);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
        vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Round-robin command scheduler in front of a single busy/idle command executor.
// Optional handshake watchdog enabled by defining CMD_SCHED_TIMEOUT_EN.
module cmd_scheduler
  import cmd_sched_pkg::*;
#(
  parameter int          N_REQ      = 4,
  parameter int          CMD_W      = 2,
  parameter int unsigned GAP_CYCLES = 25000000,
  parameter int unsigned TMO_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CMD_W-1:0] req_cmd,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [CMD_W-1:0]       command_1,
  output logic                   start,
  input  logic                   ready_command,
  output logic                   busy,
  output logic                   tmo_err
);

  localparam int           IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned  CNT_MAX  = max_u(GAP_CYCLES, TMO_CYCLES);
  localparam int           CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam sched_state_t POST_ST  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
`ifdef CMD_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYCLES > 0) ? TMO_CYCLES - 1 : 0);
`endif

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_d, done_d;
  logic [CMD_W-1:0] cmd_d;
  logic             start_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

`ifdef CMD_SCHED_TIMEOUT_EN
  logic tmo_q, tmo_d;
  assign tmo_err = tmo_q;
`else
  assign tmo_err = 1'b0;
`endif

  assign busy = (state_q != ST_IDLE);

  // One counter serves both the inter-command gap and the handshake watchdog;
  // it is cleared on every entry into a WAIT state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    done_d  = '0;
    start_d = 1'b0;
    cmd_d   = command_1;
`ifdef CMD_SCHED_TIMEOUT_EN
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_vld && ready_command) begin
          grant_d = arb_gnt;
          start_d = 1'b1;
          cmd_d   = req_cmd[arb_idx*CMD_W +: CMD_W];
          win_d   = arb_idx;
          ptr_d   = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (!ready_command) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = '0;
        end
`ifdef CMD_SCHED_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          done_d[win_q] = 1'b1;
          tmo_d         = 1'b1;
          state_d       = POST_ST;
          cnt_d         = GAP_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (ready_command) begin
          done_d[win_q] = 1'b1;
          state_d       = POST_ST;
          cnt_d         = GAP_LOAD;
        end
`ifdef CMD_SCHED_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          done_d[win_q] = 1'b1;
          tmo_d         = 1'b1;
          state_d       = POST_ST;
          cnt_d         = GAP_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      grant     <= '0;
      done      <= '0;
      start     <= 1'b0;
      command_1 <= CMD_W'(CMD_NOP);
`ifdef CMD_SCHED_TIMEOUT_EN
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      grant     <= grant_d;
      done      <= done_d;
      start     <= start_d;
      command_1 <= cmd_d;
`ifdef CMD_SCHED_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed bench for cmd_scheduler (GAP_CYCLES=4, TMO_CYCLES=8): vector table
// for a single-requester flow plus sequences for fairness, busy executor, watchdog and reset.
module tb_cmd_scheduler;
  import cmd_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] req_cmd = '0;
  logic [3:0] grant, done;
  logic [1:0] command_1;
  logic       start, busy, tmo_err;
  logic       ready_command = 1'b1;

  cmd_scheduler #(
    .N_REQ(4), .CMD_W(2), .GAP_CYCLES(4), .TMO_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .grant(grant), .done(done),
    .command_1(command_1), .start(start), .ready_command(ready_command), .busy(busy),
    .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [1:0] cmd;
    logic       rdy;
    logic [3:0] grant;
    logic       start;
    logic [3:0] done;
    logic [1:0] cmd1;
    logic       busy;
  } vec_t;

  vec_t vecs[14];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (grant != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int last_g;
    logic [7:0] std_cmd;
    std_cmd = {CMD_CFG, CMD_RX, CMD_TX, CMD_NOP};

    //             req      cmd  rdy  grant    st    done     cmd1 busy
    vecs[0]  = '{4'b0000, 2'd1, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{4'b0100, 2'd1, 1'b1, 4'b0100, 1'b1, 4'b0000, 2'd1, 1'b1};
    vecs[2]  = '{4'b0000, 2'd2, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1};
    vecs[3]  = '{4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1};
    vecs[4]  = '{4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1};
    vecs[5]  = '{4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1};
    vecs[6]  = '{4'b0100, 2'd3, 1'b1, 4'b0000, 1'b0, 4'b0100, 2'd1, 1'b1};
    vecs[7]  = '{4'b0100, 2'd3, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1};
    vecs[8]  = '{4'b0100, 2'd3, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1};
    vecs[9]  = '{4'b0100, 2'd3, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1};
    vecs[10] = '{4'b0100, 2'd3, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};
    vecs[11] = '{4'b0100, 2'd3, 1'b1, 4'b0100, 1'b1, 4'b0000, 2'd3, 1'b1};
    vecs[12] = '{4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b1};
    vecs[13] = '{4'b0000, 2'd0, 1'b1, 4'b0000, 1'b0, 4'b0100, 2'd3, 1'b1};

    // Reset with every requester active
    req = 4'b1111;
    req_cmd = std_cmd;
    ready_command = 1'b1;
    step();
    step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tmo", 32'(tmo_err), 0);
    chk("rst_cmd", 32'(command_1), 0);
    rst = 1'b1;

    // Fairness: grants 0,1,2,3,0 with 3-cycle handshake, 8 cycles apart
    last_g = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(20, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL fair_grant_timeout: no grant %0d within 20 cycles", k);
      end
      chk($sformatf("fair%0d_grant", k), 32'(grant), 32'(1 << (k % 4)));
      chk($sformatf("fair%0d_start", k), 32'(start), 1);
      chk($sformatf("fair%0d_cmd", k), 32'(command_1), 32'(k % 4));
      if (k > 0) chk($sformatf("fair%0d_spacing", k), 32'(cyc - last_g), 8);
      last_g = cyc;
      ready_command = 1'b0;
      step();
      step();
      ready_command = 1'b1;
      step();
      chk($sformatf("fair%0d_done", k), 32'(done), 32'(1 << (k % 4)));
    end
    req = 4'b0000;
    for (int i = 0; i < 5; i++) step();

    // Single command table
    for (int i = 0; i < 14; i++) begin
      req = vecs[i].req;
      req_cmd = {4{vecs[i].cmd}};
      ready_command = vecs[i].rdy;
      step();
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("v%0d_start", i), 32'(start), 32'(vecs[i].start));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("v%0d_cmd", i), 32'(command_1), 32'(vecs[i].cmd1));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // Executor busy in IDLE holds off the grant
    req_cmd = std_cmd;
    req = 4'b0010;
    ready_command = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("bsy%0d_grant", i), 32'(grant), 0);
    end
    chk("bsy_idle", 32'(busy), 0);
    ready_command = 1'b1;
    step();
    chk("bsy_grant", 32'(grant), 32'(4'b0010));
    chk("bsy_start", 32'(start), 1);
    chk("bsy_cmd", 32'(command_1), 32'(CMD_TX));
    req = 4'b0000;
    ready_command = 1'b0;
    step();
    ready_command = 1'b1;
    step();
    chk("bsy_done", 32'(done), 32'(4'b0010));
    for (int i = 0; i < 5; i++) step();

    // Executor never acknowledges
    req = 4'b1000;
    step();
    chk("wd_grant", 32'(grant), 32'(4'b1000));
    chk("wd_cmd", 32'(command_1), 32'(CMD_CFG));
    req = 4'b0000;
`ifdef CMD_SCHED_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("wd%0d_done", i), 32'(done), (i == 8) ? 32'(4'b1000) : 0);
      chk($sformatf("wd%0d_tmo", i), 32'(tmo_err), (i == 8) ? 1 : 0);
    end
    step();
    chk("wd_done_clear", 32'(done), 0);
    chk("wd_tmo_clear", 32'(tmo_err), 0);
`else
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("wd%0d_busy", i), 32'(busy), 1);
      chk($sformatf("wd%0d_done", i), 32'(done), 0);
      chk($sformatf("wd%0d_tmo", i), 32'(tmo_err), 0);
    end
`endif

    // Reset mid-operation
    rst = 1'b0;
    #1;
    chk("mid0_busy", 32'(busy), 0);
    step();
    rst = 1'b1;
    req = 4'b0100;
    ready_command = 1'b1;
    step();
    chk("mid_grant", 32'(grant), 32'(4'b0100));
    req = 4'b0000;
    ready_command = 1'b0;
    step();
    chk("mid_wait_busy", 32'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_cmd", 32'(command_1), 0);
    chk("mid_start", 32'(start), 0);
    ready_command = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid%0d_done", i), 32'(done), 0);
    end
    rst = 1'b1;
    req = 4'b1111;
    step();
    chk("mid_ptr_grant", 32'(grant), 32'(4'b0001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
